uart_tx_fsm: RTL and testbench

//  UART transmitter and the transmit counterpart of the UART RX path in the same link.

---
 rtl/uart_tx_fsm.sv | 93 +++++++++
 tb/tb_uart_tx_fsm.sv | 95 +++++++++
 2 files changed

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: 8N1/8P1 UART transmitter with a registered glitch-free line output.
// A word is latched on the accepting edge, so later port changes cannot disturb the frame.
module uart_tx_fsm #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] p_data,
  input  logic              data_valid,
  input  logic              par_en,
  input  logic              par_typ,
  input  logic [5:0]        Prescale,
  output logic              tx_out,
  output logic              busy,
  output logic              ready
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t            state_q, state_d;
  logic [5:0]        edge_cnt_q, edge_cnt_d, pre_q, pre_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_en_q, par_en_d, par_bit_q, par_bit_d;
  logic              tx_q, tx_d, busy_q;
  logic              wrap, accept;
  assign wrap   = edge_cnt_q == pre_q - 6'd1;
  assign ready  = (state_q == IDLE) | (state_q == STOP & wrap);
  assign accept = data_valid & ready;
  assign tx_out = tx_q;
  assign busy   = busy_q;
  always_comb begin
    state_d    = state_q;
    edge_cnt_d = wrap ? 6'd0 : edge_cnt_q + 6'd1;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    pre_d      = pre_q;
    case (state_q)
      IDLE: begin
        edge_cnt_d = 6'd0;
        if (accept) state_d = START;
      end
      START: if (wrap) begin
        state_d   = DATA;
        bit_cnt_d = 3'd0;
      end
      DATA: if (wrap) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'(DATA_W - 1)) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: if (wrap) state_d = STOP;
      STOP: if (wrap) state_d = accept ? START : IDLE;
      default: begin
        state_d    = IDLE;
        edge_cnt_d = 6'd0;
      end
    endcase
    if (accept) begin
      data_d     = p_data;
      par_en_d   = par_en;
      par_bit_d  = ^p_data ^ par_typ;
      pre_d      = (Prescale == 6'd0) ? 6'd1 : Prescale;
      edge_cnt_d = 6'd0;
    end
    // Line level follows the next state so tx_out is a plain flop output.
    tx_d = (state_d == START)  ? 1'b0 :
           (state_d == DATA)   ? data_d[bit_cnt_d] :
           (state_d == PARITY) ? par_bit_d : 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      pre_q      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      pre_q      <= pre_d;
      tx_q       <= tx_d;
      busy_q     <= state_d != IDLE;
    end
  end
endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb_uart_tx_fsm: drives directed and random frames and checks tx_out/busy/ready every cycle
// against a frame built from the word, parity rule and bit period.
module tb_uart_tx_fsm;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid, par_en, par_typ;
  logic [5:0] Prescale;
  logic       tx_out, busy, ready;
  int         total = 0;
  int         bad = 0;
  uart_tx_fsm dut (
    .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid), .par_en(par_en),
    .par_typ(par_typ), .Prescale(Prescale), .tx_out(tx_out), .busy(busy), .ready(ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Drive a word, let it be accepted, then check every cycle of its frame.
  task automatic frame(input logic [7:0] w, input logic pen, input logic pt, input logic [5:0] pre,
                       input bit scramble, input int pulse_k, input bit hold, input int abort_k);
    int   pe, n;
    logic bits [11];
    pe = (pre == 0) ? 1 : int'(pre);
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = w[i];
    bits[9]  = pen ? (^w ^ pt) : 1'b1;
    bits[10] = 1'b1;
    n = pe * (pen ? 11 : 10);
    p_data = w; par_en = pen; par_typ = pt; Prescale = pre; data_valid = 1'b1;
    @(posedge clk);
    #1 if (!hold) data_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == abort_k) begin
        rst = 1'b0;
        #1;
        chk("abort_tx", {7'd0, tx_out}, 8'd1);
        chk("abort_busy", {7'd0, busy}, 8'd0);
        chk("abort_ready", {7'd0, ready}, 8'd1);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      chk($sformatf("tx w=%0h k=%0d", w, k), {7'd0, tx_out}, {7'd0, bits[k/pe]});
      chk($sformatf("busy w=%0h k=%0d", w, k), {7'd0, busy}, 8'd1);
      chk($sformatf("ready w=%0h k=%0d", w, k), {7'd0, ready}, {7'd0, k == n - 1});
      if (scramble) begin
        p_data = 8'($urandom); par_en = 1'($urandom); par_typ = 1'($urandom);
        Prescale = 6'($urandom_range(1, 63));
      end
      if (k == pulse_k) data_valid = 1'b1;
      if (k == pulse_k + 1) data_valid = 1'b0;
    end
    if (!hold) begin
      @(negedge clk);
      chk("idle_tx", {7'd0, tx_out}, 8'd1);
      chk("idle_busy", {7'd0, busy}, 8'd0);
      chk("idle_ready", {7'd0, ready}, 8'd1);
    end
  endtask
  initial begin
    rst = 1'b0; data_valid = 1'b0; p_data = '0; par_en = 1'b0; par_typ = 1'b0; Prescale = 6'd8;
    repeat (2) @(negedge clk);
    chk("rst_tx", {7'd0, tx_out}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_ready", {7'd0, ready}, 8'd1);
    rst = 1'b1;
    @(negedge clk);
    frame(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0, -10, 1'b0, -1);
    frame(8'hA5, 1'b1, 1'b0, 6'd8, 1'b0, -10, 1'b0, -1);
    frame(8'hA5, 1'b1, 1'b1, 6'd8, 1'b0, -10, 1'b0, -1);
    frame(8'h01, 1'b1, 1'b0, 6'd4, 1'b1, -10, 1'b0, -1);
    frame(8'h55, 1'b0, 1'b0, 6'd8, 1'b0, -10, 1'b1, -1);
    frame(8'h0F, 1'b0, 1'b0, 6'd8, 1'b0, -10, 1'b0, -1);
    frame(8'hC3, 1'b1, 1'b1, 6'd5, 1'b0, 22, 1'b0, -1);
    frame(8'h96, 1'b1, 1'b0, 6'd1, 1'b0, -10, 1'b0, -1);
    frame(8'h69, 1'b1, 1'b1, 6'd0, 1'b0, -10, 1'b0, -1);
    frame(8'h5A, 1'b0, 1'b0, 6'd1, 1'b0, -10, 1'b1, -1);
    frame(8'hE7, 1'b1, 1'b0, 6'd1, 1'b0, -10, 1'b0, -1);
    frame(8'hAA, 1'b0, 1'b0, 6'd8, 1'b0, -10, 1'b0, 35);
    frame(8'h3C, 1'b0, 1'b0, 6'd8, 1'b0, -10, 1'b0, -1);
    for (int i = 0; i < 20; i++)
      frame(8'($urandom), 1'($urandom), 1'($urandom), 6'($urandom_range(1, 12)),
            1'($urandom), -10, (i % 4 == 1), -1);
    frame(8'h81, 1'b1, 1'b1, 6'd63, 1'b0, -10, 1'b0, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
